// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, reset value and ExcCodes.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int BD_BIT  = 31;
    localparam int TI_BIT  = 30;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 8;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;
    localparam int IM_HI   = 15;
    localparam int IM_LO   = 8;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    localparam logic [31:0] STATUS_RST_DEFAULT = 32'h0040_0000;
    // Status bits backed by flops; everything else reads as the reset constant.
    localparam logic [31:0] STATUS_WMASK       = 32'h0000_FF03;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exc_code_e;

endpackage

// File: rtl/cp0_regfile_if.sv
// Bundle between the pipeline (master) and the CP0 register file (slave).
interface cp0_regfile_if;

    logic [5:0]  hw_int;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic        exc_bva_we;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_req;

    modport master (
        output hw_int, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
               exc_valid, exc_code, exc_bd, exc_epc, exc_bva_we, exc_badvaddr, eret,
        input  mfc0_rdata, status_o, cause_o, epc_o, int_req
    );

    modport slave (
        input  hw_int, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
               exc_valid, exc_code, exc_bd, exc_epc, exc_bva_we, exc_badvaddr, eret,
        output mfc0_rdata, status_o, cause_o, epc_o, int_req
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare match raises a sticky TI flag.
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam logic [1:0] DIV_LAST = 2'(COUNT_DIV - 1);

    logic [1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            div_cnt <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count   <= wdata;
                div_cnt <= '0;
            end else if (div_cnt == DIV_LAST) begin
                count   <= count + 32'd1;
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 2'd1;
            end

            // A Compare write acknowledges the interrupt and masks a match on the same edge.
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti      <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: exception/ERET/MTC0 commit, interrupt sampling and MFC0 read mux.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEFAULT,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic          clk,
    input  logic          rst,
    cp0_regfile_if.slave  bus
);

    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code_q;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [31:0] status;
    logic [31:0] cause;
    logic        mtc0_go;

    // An exception or ERET in the same cycle drops the MTC0 completely, timer included.
    assign mtc0_go = bus.mtc0_we & ~bus.exc_valid & ~bus.eret;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0_go && (bus.mtc0_addr == REG_COUNT)),
        .compare_we (mtc0_go && (bus.mtc0_addr == REG_COMPARE)),
        .wdata      (bus.mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            im         <= STATUS_RST[IM_HI:IM_LO];
            exl        <= STATUS_RST[EXL_BIT];
            ie         <= STATUS_RST[IE_BIT];
            bd         <= 1'b0;
            ip_hw      <= '0;
            ip_sw      <= '0;
            exc_code_q <= '0;
            epc        <= '0;
            badvaddr   <= '0;
        end else begin
            ip_hw <= {bus.hw_int[5] | ti, bus.hw_int[4:0]};
            if (bus.exc_valid) begin
                // A nested exception keeps the original return point.
                if (!exl) begin
                    epc <= bus.exc_epc;
                    bd  <= bus.exc_bd;
                end
                exc_code_q <= bus.exc_code;
                exl        <= 1'b1;
                if (bus.exc_bva_we) badvaddr <= bus.exc_badvaddr;
            end else if (bus.eret) begin
                exl <= 1'b0;
            end else if (mtc0_go) begin
                case (bus.mtc0_addr)
                    REG_STATUS: begin
                        im  <= bus.mtc0_wdata[IM_HI:IM_LO];
                        exl <= bus.mtc0_wdata[EXL_BIT];
                        ie  <= bus.mtc0_wdata[IE_BIT];
                    end
                    REG_CAUSE: ip_sw <= bus.mtc0_wdata[IP_LO+1:IP_LO];
                    REG_EPC:   epc   <= bus.mtc0_wdata;
                    default:   ;
                endcase
            end
        end
    end

    // NOTE: every always_comb output gets a full default first so no latch can be inferred.
    always_comb begin
        status                = STATUS_RST & ~STATUS_WMASK;
        status[IM_HI:IM_LO]   = im;
        status[EXL_BIT]       = exl;
        status[IE_BIT]        = ie;
    end

    always_comb begin
        cause                   = '0;
        cause[BD_BIT]           = bd;
        cause[TI_BIT]           = ti;
        cause[IP_HI:IP_HI-5]    = ip_hw;
        cause[IP_LO+1:IP_LO]    = ip_sw;
        cause[EXC_HI:EXC_LO]    = exc_code_q;
    end

    always_comb begin
        bus.mfc0_rdata = '0;
        case (bus.mfc0_addr)
            REG_BADVADDR: bus.mfc0_rdata = badvaddr;
            REG_COUNT:    bus.mfc0_rdata = count;
            REG_COMPARE:  bus.mfc0_rdata = compare;
            REG_STATUS:   bus.mfc0_rdata = status;
            REG_CAUSE:    bus.mfc0_rdata = cause;
            REG_EPC:      bus.mfc0_rdata = epc;
            default:      bus.mfc0_rdata = '0;
        endcase
    end

    assign bus.status_o = status;
    assign bus.cause_o  = cause;
    assign bus.epc_o    = epc;
    assign bus.int_req  = ie & ~exl & |(cause[IP_HI:IP_LO] & im);

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios then randomized traffic against a model.
module tb_cp0_regfile;
    import cp0_pkg::*;

    localparam int DIV = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cp0_regfile_if bus ();

    cp0_regfile #(.STATUS_RST(32'h0040_0000), .COUNT_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural reference state.
    logic [31:0] m_count, m_compare, m_epc, m_bva;
    int          m_div;
    bit          m_ti, m_bd, m_exl, m_ie;
    logic [7:0]  m_im;
    logic [5:0]  m_iphw;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_iphw) << 10)
             | (32'(m_ipsw) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_read(input int addr);
        case (addr)
            8:  return m_bva;
            9:  return m_count;
            11: return m_compare;
            12: return m_status();
            13: return m_cause();
            14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_int();
        logic [31:0] pending;
        pending = (m_cause() >> 8) & 32'(m_im);
        return (m_ie && !m_exl && pending != 0) ? 32'd1 : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.mtc0_we      = 1'b0;
        bus.mtc0_addr    = '0;
        bus.mtc0_wdata   = '0;
        bus.exc_valid    = 1'b0;
        bus.exc_code     = '0;
        bus.exc_bd       = 1'b0;
        bus.exc_epc      = '0;
        bus.exc_bva_we   = 1'b0;
        bus.exc_badvaddr = '0;
        bus.eret         = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        int addrs[7];
        int u;
        check({tag, ":status_o"}, bus.status_o, m_status());
        check({tag, ":cause_o"},  bus.cause_o,  m_cause());
        check({tag, ":epc_o"},    bus.epc_o,    m_epc);
        check({tag, ":int_req"},  32'(bus.int_req), m_int());
        do u = int'($urandom_range(0, 31));
        while (u == 8 || u == 9 || u == 11 || u == 12 || u == 13 || u == 14);
        addrs = '{8, 9, 11, 12, 13, 14, u};
        foreach (addrs[i]) begin
            bus.mfc0_addr = 5'(addrs[i]);
            #1;
            check($sformatf("%s:mfc0[%0d]", tag, addrs[i]), bus.mfc0_rdata, m_read(addrs[i]));
        end
    endtask

    // Advance one clock: the model consumes the inputs present before the edge.
    task automatic tick(input string tag);
        logic [31:0] wd;
        bit          go;
        int          a;
        wd = bus.mtc0_wdata;
        a  = int'(bus.mtc0_addr);
        go = bus.mtc0_we && !bus.exc_valid && !bus.eret;
        @(posedge clk);
        if (rst) begin
            m_count = 0; m_compare = 0; m_epc = 0; m_bva = 0; m_div = 0;
            m_ti = 0; m_bd = 0; m_exl = 0; m_ie = 0; m_im = 0;
            m_iphw = 0; m_ipsw = 0; m_code = 0;
        end else begin
            logic [31:0] old_count;
            logic        old_ti;
            old_count = m_count;
            old_ti    = m_ti;
            // timer
            if (go && a == 9) begin
                m_count = wd;
                m_div   = 0;
            end else if (m_div == DIV - 1) begin
                m_count = m_count + 1;
                m_div   = 0;
            end else begin
                m_div = m_div + 1;
            end
            if (go && a == 11) begin
                m_compare = wd;
                m_ti      = 0;
            end else if (old_count == m_compare) begin
                m_ti = 1;
            end
            m_iphw = bus.hw_int | (old_ti ? 6'h20 : 6'h00);
            // commit
            if (bus.exc_valid) begin
                if (!m_exl) begin
                    m_epc = bus.exc_epc;
                    m_bd  = bus.exc_bd;
                end
                m_code = bus.exc_code;
                m_exl  = 1;
                if (bus.exc_bva_we) m_bva = bus.exc_badvaddr;
            end else if (bus.eret) begin
                m_exl = 0;
            end else if (go) begin
                if (a == 12) begin
                    m_im  = wd[15:8];
                    m_exl = wd[1];
                    m_ie  = wd[0];
                end else if (a == 13) begin
                    m_ipsw = wd[9:8];
                end else if (a == 14) begin
                    m_epc = wd;
                end
            end
        end
        #1;
        compare_all(tag);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data, input string tag);
        idle_inputs();
        bus.mtc0_we    = 1'b1;
        bus.mtc0_addr  = addr;
        bus.mtc0_wdata = data;
        tick(tag);
        idle_inputs();
    endtask

    initial begin
        int ti_cycle;
        int ip7_cycle;
        int wlist[8];
        wlist = '{8, 9, 11, 12, 13, 14, 0, 31};

        // Reset state, observed while reset is still held.
        rst = 1'b1;
        bus.hw_int = '0;
        bus.mfc0_addr = '0;
        idle_inputs();
        tick("reset0");
        tick("reset1");
        bus.mfc0_addr = REG_STATUS; #1; check("rst_status", bus.mfc0_rdata, 32'h0040_0000);
        bus.mfc0_addr = REG_CAUSE;  #1; check("rst_cause",  bus.mfc0_rdata, 32'h0);
        bus.mfc0_addr = REG_EPC;    #1; check("rst_epc",    bus.mfc0_rdata, 32'h0);
        bus.mfc0_addr = REG_BADVADDR; #1; check("rst_bva",  bus.mfc0_rdata, 32'h0);
        check("rst_int_req", 32'(bus.int_req), 32'h0);

        // Park Compare far away so TI stays clear for the directed steps.
        rst = 1'b0;
        mtc0(REG_COMPARE, 32'hFFFF_FFFF, "park_compare");
        tick("idle0");

        // First exception with EXL=0.
        bus.exc_valid = 1'b1; bus.exc_code = EXC_OV; bus.exc_epc = 32'hBFC0_0100; bus.exc_bd = 1'b1;
        tick("exc1");
        idle_inputs();
        check("exc1_epc",   bus.epc_o,   32'hBFC0_0100);
        check("exc1_cause", bus.cause_o, 32'h8000_0030);
        check("exc1_exl",   32'(bus.status_o[1]), 32'h1);

        // Nested exception keeps EPC/BD, updates ExcCode and BadVAddr.
        bus.exc_valid = 1'b1; bus.exc_code = EXC_ADEL; bus.exc_epc = 32'h0000_1234; bus.exc_bd = 1'b0;
        bus.exc_bva_we = 1'b1; bus.exc_badvaddr = 32'hDEAD_BEE1;
        tick("exc2");
        idle_inputs();
        check("exc2_epc",   bus.epc_o,   32'hBFC0_0100);
        check("exc2_cause", bus.cause_o, 32'h8000_0010);
        bus.mfc0_addr = REG_BADVADDR; #1; check("exc2_bva", bus.mfc0_rdata, 32'hDEAD_BEE1);
        bus.eret = 1'b1;
        tick("eret1");
        idle_inputs();
        check("eret1_status", bus.status_o, 32'h0040_0000);

        // Timer: Count=0 at cycle 0, Compare=5 at cycle 1, TI expected at cycle 11, IP7 at 12.
        ti_cycle  = -1;
        ip7_cycle = -1;
        mtc0(REG_COUNT, 32'h0, "count0");
        mtc0(REG_COMPARE, 32'h5, "compare5");
        for (int c = 2; c <= 30; c++) begin
            tick("timer");
            if (bus.cause_o[30] && ti_cycle < 0)  ti_cycle  = c;
            if (bus.cause_o[15] && ip7_cycle < 0) ip7_cycle = c;
        end
        check("ti_cycle",  32'(ti_cycle),  32'd11);
        check("ip7_cycle", 32'(ip7_cycle), 32'd12);
        mtc0(REG_COMPARE, 32'h9, "compare9");
        check("ti_clear", 32'(bus.cause_o[30]), 32'h0);

        // Hardware interrupt sampling and masking.
        bus.hw_int = 6'b000100;
        mtc0(REG_STATUS, 32'h0000_FF01, "status_im");
        check("hw_ip12",    32'(bus.cause_o[12]), 32'h1);
        check("hw_int_req", 32'(bus.int_req),     32'h1);
        mtc0(REG_STATUS, 32'h0000_FF03, "status_exl");
        check("exl_int_req", 32'(bus.int_req), 32'h0);

        // Exception beats ERET and MTC0 on the same edge.
        bus.exc_valid = 1'b1; bus.exc_code = EXC_SYS; bus.exc_epc = 32'h0000_4000;
        bus.eret = 1'b1;
        bus.mtc0_we = 1'b1; bus.mtc0_addr = REG_STATUS; bus.mtc0_wdata = 32'h0;
        tick("prio");
        idle_inputs();
        check("prio_status", bus.status_o, 32'h0040_FF03);
        bus.hw_int = '0;
        bus.eret = 1'b1;
        tick("eret2");
        idle_inputs();

        // Count wraps modulo 2^32.
        mtc0(REG_COUNT, 32'hFFFF_FFFF, "count_max");
        tick("wrap_a");
        tick("wrap_b");
        bus.mfc0_addr = REG_COUNT; #1; check("count_wrap", bus.mfc0_rdata, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            rst              = ($urandom_range(0, 99) == 0);
            bus.hw_int       = 6'($urandom);
            bus.exc_valid    = ($urandom_range(0, 7) == 0);
            bus.exc_code     = 5'($urandom);
            bus.exc_bd       = 1'($urandom);
            bus.exc_epc      = $urandom;
            bus.exc_bva_we   = 1'($urandom);
            bus.exc_badvaddr = $urandom;
            bus.eret         = ($urandom_range(0, 7) == 0);
            bus.mtc0_we      = ($urandom_range(0, 2) == 0);
            bus.mtc0_addr    = 5'(wlist[$urandom_range(0, 7)]);
            bus.mtc0_wdata   = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom;
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
